addsub_pipe: RTL

// Parametrised, pipelined integer adder/subtractor; next generation of the 8-bit ripple add/sub.

---
 rtl/addsub_pipe_if.sv | 30 +++
 rtl/addsub_pipe.sv | 87 ++++++++
 2 files changed

// File: rtl/addsub_pipe_if.sv
// Operand/result bundle for the pipelined adder/subtractor.
// Latency: none (wires only).
// Backpressure: in_ready driven by the slave; out_ready driven by the master.
interface addsub_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             flag_c;
    logic             flag_v;
    logic             flag_n;
    logic             flag_z;

    modport master (
        output in_valid, a, b, op, cin, out_ready,
        input  in_ready, out_valid, sum, flag_c, flag_v, flag_n, flag_z
    );

    modport slave (
        input  in_valid, a, b, op, cin, out_ready,
        output in_ready, out_valid, sum, flag_c, flag_v, flag_n, flag_z
    );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit add/sub (ADD/SUB/ADC/SBC) with N/Z/C/V flags, carry chain cut into STAGES slices.
// Latency: STAGES registers; a beat accepted on edge t is on the outputs after edge t+STAGES-1.
// Backpressure: whole pipe advances when output is empty or taken; in_ready mirrors that advance.
module addsub_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    addsub_pipe_if.slave bus
);
    localparam int SW  = WIDTH / STAGES;
    localparam int MSB = WIDTH - 1;

    // One pipeline slot: full operands ride along so later slices can add their bits;
    // s accumulates result slices from the bottom up, c/z carry the chain forward.
    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] bx;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             z;
    } stage_t;

    stage_t stage_q [STAGES];
    stage_t stage_d [STAGES];
    logic   advance;

    // Single global enable: the pipe moves only when the last slot can be vacated.
    assign advance      = !stage_q[STAGES-1].vld || bus.out_ready;
    assign bus.in_ready = advance;

    // Next-state of every slot: hold when stalled, otherwise add one slice per stage.
    always_comb begin
        logic [SW:0] part;
        for (int k = 0; k < STAGES; k++) begin
            stage_d[k] = stage_q[k];
        end
        part = '0;
        if (advance) begin
            // First slice: invert b for subtracts, pick carry-in from op.
            stage_d[0].vld = bus.in_valid;
            stage_d[0].a   = bus.a;
            stage_d[0].bx  = bus.b ^ {WIDTH{bus.op[0]}};
            part = {1'b0, bus.a[SW-1:0]}
                 + {1'b0, stage_d[0].bx[SW-1:0]}
                 + {{SW{1'b0}}, (bus.op[1] ? bus.cin : bus.op[0])};
            stage_d[0].s         = '0;
            stage_d[0].s[SW-1:0] = part[SW-1:0];
            stage_d[0].c         = part[SW];
            stage_d[0].z         = (part[SW-1:0] == '0);
            // Later slices consume the registered carry of the previous slice.
            for (int k = 1; k < STAGES; k++) begin
                stage_d[k] = stage_q[k-1];
                part = {1'b0, stage_q[k-1].a[k*SW +: SW]}
                     + {1'b0, stage_q[k-1].bx[k*SW +: SW]}
                     + {{SW{1'b0}}, stage_q[k-1].c};
                stage_d[k].s[k*SW +: SW] = part[SW-1:0];
                stage_d[k].c             = part[SW];
                stage_d[k].z             = stage_q[k-1].z && (part[SW-1:0] == '0);
            end
        end
    end

    // Stage registers; reset empties the pipe and clears result/flags at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    // Overflow needs the sign bits of a and the possibly-inverted b, both carried to the end.
    assign bus.out_valid = stage_q[STAGES-1].vld;
    assign bus.sum       = stage_q[STAGES-1].s;
    assign bus.flag_c    = stage_q[STAGES-1].c;
    assign bus.flag_n    = stage_q[STAGES-1].s[MSB];
    assign bus.flag_z    = stage_q[STAGES-1].z;
    assign bus.flag_v    = (stage_q[STAGES-1].a[MSB] == stage_q[STAGES-1].bx[MSB])
                        && (stage_q[STAGES-1].s[MSB] != stage_q[STAGES-1].a[MSB]);
endmodule
